// File: rtl/lab1_imul_int_mul_iter.sv
// lab1_imul_int_mul_iter: iterative 32-bit shift-and-add multiplier with val/rdy request and response ports
module lab1_imul_int_mul_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_val,
  output logic        req_rdy,
  input  logic [63:0] req_msg,
  output logic        resp_val,
  input  logic        resp_rdy,
  output logic [31:0] resp_msg
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_next;
  logic [31:0] a_reg, b_reg, result_reg;
  logic [5:0] counter;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      counter    <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_val) begin
        a_reg      <= req_msg[63:32];
        b_reg      <= req_msg[31:0];
        result_reg <= '0;
        counter    <= '0;
      end else if (state == CALC) begin
        result_reg <= b_reg[0] ? result_reg + a_reg : result_reg;
        a_reg      <= a_reg << 1;
        b_reg      <= b_reg >> 1;
        counter    <= counter + 6'd1;
      end
    end
  always_comb begin
    state_next = state == IDLE ? (req_val ? CALC : IDLE)
               : state == CALC ? (counter == 6'd31 ? DONE : CALC)
               : (resp_rdy ? IDLE : DONE);
    req_rdy    = state == IDLE;
    resp_val   = state == DONE;
    resp_msg   = result_reg;
  end
endmodule
